multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter TIMEOUT, default 16: memory-wait cycles allowed before fault; legal range 2..255.
REQ-002 Parameter CNT_W, default 8: timeout counter width; SHALL be at least clog2(TIMEOUT).
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 enable  in  1  0 = processor frozen.
REQ-006 op  in  6  opcode field of the instruction register.
REQ-007 func  in  6  function field of the instruction register.
REQ-008 Z  in  1  ALU zero flag.
REQ-009 mem_ready  in  1  memory completion strobe.
REQ-010 mem_req  out  1  memory access request.
REQ-011 irwrite, pcwrite, werf, wr  out  1 each  instruction-register, PC, register-file and data-memory write strobes.
REQ-012 pcsel, wasel, wdsel, asel  out  2 each  datapath multiplexer selects.
REQ-013 bsel, sext  out  1 each  B-operand select and sign-extend select.
REQ-014 alufn  out  5  ALU function code.
REQ-015 illegal  out  1  one-cycle pulse on an undecodable instruction.
REQ-016 fault  out  1  sticky memory-timeout flag.

Function
REQ-017 The FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-018 In FETCH, mem_req SHALL be 1; on mem_ready, irwrite=1, pcwrite=1 and pcsel=00 for that cycle, then the FSM SHALL go to DECODE.
REQ-019 In DECODE, an illegal op/func SHALL pulse illegal and return to FETCH with no writes.
REQ-020 In DECODE, J SHALL write the PC with pcsel=10, JR with pcsel=11, and JAL with pcsel=10 plus werf=1, wasel=10, wdsel=00, each then going to FETCH.
REQ-021 All other legal instructions SHALL go from DECODE to EXEC.
REQ-022 In EXEC, BEQ SHALL assert pcwrite with pcsel=01 only if Z=1, BNE only if Z=0, then go to FETCH.
REQ-023 In EXEC, LW and SW SHALL go to MEM, and ALU instructions to WB.
REQ-024 In MEM, mem_req SHALL be 1 and, for SW, wr SHALL be 1; on mem_ready, LW SHALL go to WB and SW to FETCH.
REQ-025 In WB, werf SHALL be 1 for exactly one cycle, then go to FETCH.
REQ-026 LW write-back SHALL use wdsel=10, ALU and immediate write-back wdsel=01, R-type wasel=00, and immediate and LW wasel=01.
REQ-027 Selects and alufn SHALL be decoded combinationally from op/func in every state; don't-care bits SHALL drive 0.
REQ-028 alufn SHALL be: add/addi/addiu/lw/sw 00001, sub/beq/bne 10001, slt/slti 10011, sltu/sltiu 10111, and 00000, or 00100, xor 01000, nor 01100, sll/sllv/lui 00010, srl 01010, sra 01110.
REQ-029 asel SHALL be 01 for sll/srl/sra, 10 for lui, else 00; bsel=1 for immediate forms and LW/SW; sext=0 for andi/ori/xori/lui, else 1.
REQ-030 A wait counter SHALL clear on entering FETCH or MEM and increment each enabled cycle without mem_ready.
REQ-031 When the counter reaches TIMEOUT-1 without mem_ready, the FSM SHALL enter HALT and set fault.
REQ-032 mem_ready and the timeout in the same cycle SHALL resolve in favour of mem_ready.
REQ-033 HALT SHALL be exited only by reset; all strobes and mem_req SHALL be 0 in HALT.
REQ-034 While enable=0, the state and counter SHALL hold, and mem_req, irwrite, pcwrite, werf, wr and illegal SHALL be 0.
REQ-035 mem_ready SHALL be ignored outside FETCH and MEM.

Reset
REQ-036 Reset SHALL force state=FETCH, counter=0, fault=0 and all strobes=0, and SHALL take priority over enable.
REQ-037 Reset asserted mid-MEM SHALL suppress wr in that cycle.
REQ-038 FETCH SHALL assert mem_req in the first cycle after reset deasserts.

Structure
REQ-039 Opcode/func constants, alufn constants and the state_t enum SHALL reside in mips_pkg.
REQ-040 Combinational decode (selects, alufn, instruction class, legality) SHALL be the sub-module mc_decode; the FSM and counter SHALL reside in multicycle_controller.

Verification
REQ-041 Bench case: ADD (op=0, func=100000) with mem_ready=1 in the first FETCH cycle -> FETCH-DECODE-EXEC-WB in 4 cycles, one werf pulse, alufn=00001.
REQ-042 Bench case: LW with data-memory mem_ready after 3 cycles -> wdsel=10, werf in WB, instruction total 8 cycles.
REQ-043 Bench case: BEQ with Z=1 then Z=0 -> pcwrite with pcsel=01 only in the first, 3 cycles each.
REQ-044 Bench case: TIMEOUT=4 and mem_ready held 0 in FETCH -> HALT and fault=1 after 4 cycles; strobes stay 0 until reset.
REQ-045 Bench case: enable=0 for 5 cycles during SW's MEM -> wr=0 and state held; on re-enable, wr=1 until mem_ready.
REQ-046 Bench case: op=111111 -> illegal pulses once in DECODE, no writes, return to FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode/function encodings, ALU function codes, FSM states and the
// decoded-instruction bundle for the multicycle controller.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b10001;
  localparam logic [4:0] ALU_SLT  = 5'b10011;
  localparam logic [4:0] ALU_SLTU = 5'b10111;
  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_OR   = 5'b00100;
  localparam logic [4:0] ALU_XOR  = 5'b01000;
  localparam logic [4:0] ALU_NOR  = 5'b01100;
  localparam logic [4:0] ALU_SHL  = 5'b00010;
  localparam logic [4:0] ALU_SHR  = 5'b01010;
  localparam logic [4:0] ALU_SRA  = 5'b01110;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  typedef enum logic [3:0] {
    C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILLEGAL
  } iclass_t;

  typedef struct packed {
    iclass_t    cls;
    logic [4:0] alufn;
    logic [1:0] pcsel;
    logic [1:0] wasel;
    logic [1:0] wdsel;
    logic [1:0] asel;
    logic       bsel;
    logic       sext;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Purely combinational instruction decode: class, legality, datapath selects
// and ALU function from op/func. Unused select bits are driven to 0.
module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output dec_t       dec_o
);

  logic imm_form;

  always_comb begin
    dec_o      = '0;
    dec_o.cls  = C_ILLEGAL;
    dec_o.sext = 1'b1;
    imm_form   = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        dec_o.cls   = C_ALU;
        dec_o.wdsel = 2'b01;
        case (func_i)
          FN_ADD:  dec_o.alufn = ALU_ADD;
          FN_SUB:  dec_o.alufn = ALU_SUB;
          FN_AND:  dec_o.alufn = ALU_AND;
          FN_OR:   dec_o.alufn = ALU_OR;
          FN_XOR:  dec_o.alufn = ALU_XOR;
          FN_NOR:  dec_o.alufn = ALU_NOR;
          FN_SLT:  dec_o.alufn = ALU_SLT;
          FN_SLTU: dec_o.alufn = ALU_SLTU;
          FN_SLLV: dec_o.alufn = ALU_SHL;
          FN_SLL:  begin dec_o.alufn = ALU_SHL; dec_o.asel = 2'b01; end
          FN_SRL:  begin dec_o.alufn = ALU_SHR; dec_o.asel = 2'b01; end
          FN_SRA:  begin dec_o.alufn = ALU_SRA; dec_o.asel = 2'b01; end
          FN_JR: begin
            dec_o.cls   = C_JR;
            dec_o.wdsel = 2'b00;
            dec_o.pcsel = 2'b11;
          end
          default: begin
            dec_o.cls   = C_ILLEGAL;
            dec_o.wdsel = 2'b00;
          end
        endcase
      end
      OP_J:   begin dec_o.cls = C_J;   dec_o.pcsel = 2'b10; end
      OP_JAL: begin dec_o.cls = C_JAL; dec_o.pcsel = 2'b10; dec_o.wasel = 2'b10; end
      OP_BEQ: begin dec_o.cls = C_BEQ; dec_o.pcsel = 2'b01; dec_o.alufn = ALU_SUB; end
      OP_BNE: begin dec_o.cls = C_BNE; dec_o.pcsel = 2'b01; dec_o.alufn = ALU_SUB; end
      OP_ADDI, OP_ADDIU: begin imm_form = 1'b1; dec_o.alufn = ALU_ADD; end
      OP_SLTI:  begin imm_form = 1'b1; dec_o.alufn = ALU_SLT; end
      OP_SLTIU: begin imm_form = 1'b1; dec_o.alufn = ALU_SLTU; end
      OP_ANDI:  begin imm_form = 1'b1; dec_o.alufn = ALU_AND; dec_o.sext = 1'b0; end
      OP_ORI:   begin imm_form = 1'b1; dec_o.alufn = ALU_OR;  dec_o.sext = 1'b0; end
      OP_XORI:  begin imm_form = 1'b1; dec_o.alufn = ALU_XOR; dec_o.sext = 1'b0; end
      OP_LUI: begin
        imm_form    = 1'b1;
        dec_o.alufn = ALU_SHL;
        dec_o.asel  = 2'b10;
        dec_o.sext  = 1'b0;
      end
      OP_LW: begin
        dec_o.cls   = C_LW;
        dec_o.alufn = ALU_ADD;
        dec_o.bsel  = 1'b1;
        dec_o.wasel = 2'b01;
        dec_o.wdsel = 2'b10;
      end
      OP_SW: begin
        dec_o.cls   = C_SW;
        dec_o.alufn = ALU_ADD;
        dec_o.bsel  = 1'b1;
      end
      default: dec_o.cls = C_ILLEGAL;
    endcase
    // Immediate ALU forms share operand and write-back routing.
    if (imm_form) begin
      dec_o.cls   = C_ALU;
      dec_o.bsel  = 1'b1;
      dec_o.wasel = 2'b01;
      dec_o.wdsel = 2'b01;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with memory-wait timeout; strobes are gated by
// enable and reset, selects come straight from the decoder.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       Z,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       werf,
  output logic       wr,
  output logic [1:0] pcsel,
  output logic [1:0] wasel,
  output logic [1:0] wdsel,
  output logic [1:0] asel,
  output logic       bsel,
  output logic       sext,
  output logic [4:0] alufn,
  output logic       illegal,
  output logic       fault
);

  dec_t             dec;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             go;
  logic             timeout;

  mc_decode u_decode (
    .op_i   (op),
    .func_i (func),
    .dec_o  (dec)
  );

  assign go      = enable & ~reset;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

  assign wasel = dec.wasel;
  assign wdsel = dec.wdsel;
  assign asel  = dec.asel;
  assign bsel  = dec.bsel;
  assign sext  = dec.sext;
  assign alufn = dec.alufn;
  assign fault = fault_q;
  // The IR still holds the previous instruction during FETCH.
  assign pcsel = (state_q == FETCH) ? 2'b00 : dec.pcsel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    mem_req = 1'b0;
    irwrite = 1'b0;
    pcwrite = 1'b0;
    werf    = 1'b0;
    wr      = 1'b0;
    illegal = 1'b0;
    if (go) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
            state_d = DECODE;
          end else if (timeout) begin
            state_d = HALT;
            fault_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DECODE: begin
          case (dec.cls)
            C_ILLEGAL: begin illegal = 1'b1; state_d = FETCH; cnt_d = '0; end
            C_J, C_JR: begin pcwrite = 1'b1; state_d = FETCH; cnt_d = '0; end
            C_JAL: begin
              pcwrite = 1'b1;
              werf    = 1'b1;
              state_d = FETCH;
              cnt_d   = '0;
            end
            default: state_d = EXEC;
          endcase
        end
        EXEC: begin
          case (dec.cls)
            C_BEQ: begin pcwrite = Z;  state_d = FETCH; cnt_d = '0; end
            C_BNE: begin pcwrite = ~Z; state_d = FETCH; cnt_d = '0; end
            C_LW, C_SW: begin state_d = MEM; cnt_d = '0; end
            default: state_d = WB;
          endcase
        end
        MEM: begin
          mem_req = 1'b1;
          wr      = (dec.cls == C_SW);
          if (mem_ready) begin
            state_d = (dec.cls == C_LW) ? WB : FETCH;
            cnt_d   = '0;
          end else if (timeout) begin
            state_d = HALT;
            fault_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WB: begin
          werf    = 1'b1;
          state_d = FETCH;
          cnt_d   = '0;
        end
        HALT: state_d = HALT;
        default: begin state_d = FETCH; cnt_d = '0; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench: directed instruction sequences with literal expectations, then random
// traffic checked every cycle against a table-driven behavioural model.
module tb_multicycle_controller;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset, enable, Z, mem_ready;
  logic [5:0] op, func;
  logic       mem_req, irwrite, pcwrite, werf, wr, bsel, sext, illegal, fault;
  logic [1:0] pcsel, wasel, wdsel, asel;
  logic [4:0] alufn;

  multicycle_controller #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .op(op), .func(func), .Z(Z),
    .mem_ready(mem_ready), .mem_req(mem_req), .irwrite(irwrite), .pcwrite(pcwrite),
    .werf(werf), .wr(wr), .pcsel(pcsel), .wasel(wasel), .wdsel(wdsel), .asel(asel),
    .bsel(bsel), .sext(sext), .alufn(alufn), .illegal(illegal), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction kinds, by how they move through the machine.
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5;
  localparam int K_J = 6, K_JAL = 7, K_JR = 8, K_BAD = 9;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         kind;
    logic [4:0] alu;
    logic [1:0] asel;
    logic       bsel;
    logic       sext;
  } ins_t;

  ins_t tbl[$];

  task automatic add_ins(input logic [5:0] o, input logic [5:0] f, input int k,
                         input logic [4:0] a, input logic [1:0] as, input logic b,
                         input logic s);
    ins_t e;
    e.op = o; e.fn = f; e.kind = k; e.alu = a; e.asel = as; e.bsel = b; e.sext = s;
    tbl.push_back(e);
  endtask

  function automatic int find(input logic [5:0] o, input logic [5:0] f);
    foreach (tbl[i])
      if (tbl[i].op == o && (o != 6'd0 || tbl[i].fn == f)) return i;
    return -1;
  endfunction

  // Model state: phase 0..5 = fetch, decode, exec, mem, wb, halt.
  int   m_ph, m_wait;
  logic m_fault;
  bit   chk_on = 0;

  always @(negedge clk) begin : model
    int         idx, kind;
    logic       g;
    logic [6:0] es;
    logic [14:0] ex_sel;
    logic [4:0] e_alu;
    logic [1:0] e_asel, e_pc, e_wa, e_wd;
    logic       e_b, e_s;
    if (chk_on) begin
      idx  = find(op, func);
      kind = (idx < 0) ? K_BAD : tbl[idx].kind;
      e_alu  = (idx < 0) ? 5'd0 : tbl[idx].alu;
      e_asel = (idx < 0) ? 2'd0 : tbl[idx].asel;
      e_b    = (idx < 0) ? 1'b0 : tbl[idx].bsel;
      e_s    = (idx < 0) ? 1'b1 : tbl[idx].sext;
      e_wa = (kind == K_I || kind == K_LW) ? 2'd1 : (kind == K_JAL) ? 2'd2 : 2'd0;
      e_wd = (kind == K_LW) ? 2'd2 : (kind == K_R || kind == K_I) ? 2'd1 : 2'd0;
      e_pc = (kind == K_J || kind == K_JAL) ? 2'd2 : (kind == K_JR) ? 2'd3 :
             (kind == K_BEQ || kind == K_BNE) ? 2'd1 : 2'd0;
      if (m_ph == 0) e_pc = 2'd0;
      g  = enable && !reset;
      es = '0;  // {mem_req, irwrite, pcwrite, werf, wr, illegal, fault}
      es[0] = m_fault;
      case (m_ph)
        0: begin es[6] = g; es[5] = g && mem_ready; es[4] = g && mem_ready; end
        1: begin
          es[1] = g && kind == K_BAD;
          es[4] = g && (kind == K_J || kind == K_JR || kind == K_JAL);
          es[3] = g && kind == K_JAL;
        end
        2: es[4] = g && ((kind == K_BEQ && Z) || (kind == K_BNE && !Z));
        3: begin es[6] = g; es[2] = g && kind == K_SW; end
        4: es[3] = g;
        default: ;
      endcase
      ex_sel = {e_pc, e_wa, e_wd, e_asel, e_b, e_s, e_alu};
      chk("model_strobes", {mem_req, irwrite, pcwrite, werf, wr, illegal, fault}, es);
      chk("model_selects", {pcsel, wasel, wdsel, asel, bsel, sext, alufn}, ex_sel);
      if (reset) begin
        m_ph = 0; m_wait = 0; m_fault = 1'b0;
      end else if (enable) begin
        case (m_ph)
          0, 3: begin
            if (mem_ready) begin
              if (m_ph == 0) m_ph = 1;
              else if (kind == K_LW) m_ph = 4;
              else begin m_ph = 0; m_wait = 0; end
            end else if (m_wait == TO - 1) begin
              m_ph = 5; m_fault = 1'b1;
            end else m_wait++;
          end
          1: if (kind == K_BAD || kind == K_J || kind == K_JR || kind == K_JAL) begin
               m_ph = 0; m_wait = 0;
             end else m_ph = 2;
          2: if (kind == K_BEQ || kind == K_BNE) begin m_ph = 0; m_wait = 0; end
             else if (kind == K_LW || kind == K_SW) begin m_ph = 3; m_wait = 0; end
             else m_ph = 4;
          4: begin m_ph = 0; m_wait = 0; end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [6:0] stb();
    return {mem_req, irwrite, pcwrite, werf, wr, illegal, fault};
  endfunction

  task automatic cyc(input logic en, input logic rdy, input logic z, input logic rst,
                     input logic [5:0] o, input logic [5:0] f);
    @(posedge clk);
    #1;
    enable = en; mem_ready = rdy; Z = z; reset = rst; op = o; func = f;
    @(negedge clk);
  endtask

  task automatic to_mem(input logic [5:0] o);
    cyc(1, 0, 0, 1, o, 6'h00);
    cyc(1, 1, 0, 0, o, 6'h00);
    cyc(1, 0, 0, 0, o, 6'h00);
    cyc(1, 0, 0, 0, o, 6'h00);
  endtask

  initial begin
    int wcnt;
    logic [5:0] ro, rf;
    reset = 1; enable = 0; op = 0; func = 0; Z = 0; mem_ready = 0;
    m_ph = 0; m_wait = 0; m_fault = 1'b0;
    add_ins(6'h00, 6'h20, K_R, 5'b00001, 2'd0, 0, 1);
    add_ins(6'h00, 6'h22, K_R, 5'b10001, 2'd0, 0, 1);
    add_ins(6'h00, 6'h24, K_R, 5'b00000, 2'd0, 0, 1);
    add_ins(6'h00, 6'h25, K_R, 5'b00100, 2'd0, 0, 1);
    add_ins(6'h00, 6'h26, K_R, 5'b01000, 2'd0, 0, 1);
    add_ins(6'h00, 6'h27, K_R, 5'b01100, 2'd0, 0, 1);
    add_ins(6'h00, 6'h2A, K_R, 5'b10011, 2'd0, 0, 1);
    add_ins(6'h00, 6'h2B, K_R, 5'b10111, 2'd0, 0, 1);
    add_ins(6'h00, 6'h00, K_R, 5'b00010, 2'd1, 0, 1);
    add_ins(6'h00, 6'h02, K_R, 5'b01010, 2'd1, 0, 1);
    add_ins(6'h00, 6'h03, K_R, 5'b01110, 2'd1, 0, 1);
    add_ins(6'h00, 6'h04, K_R, 5'b00010, 2'd0, 0, 1);
    add_ins(6'h00, 6'h08, K_JR, 5'b00000, 2'd0, 0, 1);
    add_ins(6'h02, 6'h00, K_J, 5'b00000, 2'd0, 0, 1);
    add_ins(6'h03, 6'h00, K_JAL, 5'b00000, 2'd0, 0, 1);
    add_ins(6'h04, 6'h00, K_BEQ, 5'b10001, 2'd0, 0, 1);
    add_ins(6'h05, 6'h00, K_BNE, 5'b10001, 2'd0, 0, 1);
    add_ins(6'h08, 6'h00, K_I, 5'b00001, 2'd0, 1, 1);
    add_ins(6'h09, 6'h00, K_I, 5'b00001, 2'd0, 1, 1);
    add_ins(6'h0A, 6'h00, K_I, 5'b10011, 2'd0, 1, 1);
    add_ins(6'h0B, 6'h00, K_I, 5'b10111, 2'd0, 1, 1);
    add_ins(6'h0C, 6'h00, K_I, 5'b00000, 2'd0, 1, 0);
    add_ins(6'h0D, 6'h00, K_I, 5'b00100, 2'd0, 1, 0);
    add_ins(6'h0E, 6'h00, K_I, 5'b01000, 2'd0, 1, 0);
    add_ins(6'h0F, 6'h00, K_I, 5'b00010, 2'd2, 1, 0);
    add_ins(6'h23, 6'h00, K_LW, 5'b00001, 2'd0, 1, 1);
    add_ins(6'h2B, 6'h00, K_SW, 5'b00001, 2'd0, 1, 1);

    @(posedge clk);
    #1;
    chk_on = 1;
    @(negedge clk);
    chk("reset_state", stb(), 7'b0000000);
    cyc(1, 0, 0, 0, 6'h00, 6'h20);
    chk("fetch_after_reset", mem_req, 1);

    // ADD: four cycles, one werf pulse.
    cyc(1, 0, 0, 1, 6'h00, 6'h20);
    cyc(1, 1, 0, 0, 6'h00, 6'h20); chk("add_fetch", stb(), 7'b1110000);
    chk("add_fetch_pcsel", pcsel, 2'b00);
    cyc(1, 0, 0, 0, 6'h00, 6'h20); chk("add_decode", stb(), 7'b0000000);
    cyc(1, 0, 0, 0, 6'h00, 6'h20); chk("add_exec", stb(), 7'b0000000);
    chk("add_alufn", alufn, 5'b00001);
    cyc(1, 0, 0, 0, 6'h00, 6'h20); chk("add_wb", stb(), 7'b0001000);
    chk("add_wb_sel", {wasel, wdsel}, 4'b0001);
    cyc(1, 0, 0, 0, 6'h00, 6'h20); chk("add_refetch", stb(), 7'b1000000);

    // LW: memory answers on the fourth MEM cycle, at the timeout boundary.
    to_mem(6'h23);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 6'h23, 6'h00); chk("lw_mem_wait", stb(), 7'b1000000);
    end
    cyc(1, 1, 0, 0, 6'h23, 6'h00); chk("lw_mem_ready", stb(), 7'b1000000);
    cyc(1, 0, 0, 0, 6'h23, 6'h00); chk("lw_wb", stb(), 7'b0001000);
    chk("lw_wb_sel", {wasel, wdsel}, 4'b0110);
    cyc(1, 0, 0, 0, 6'h23, 6'h00); chk("lw_refetch", stb(), 7'b1000000);

    // BEQ taken then not taken.
    cyc(1, 0, 0, 1, 6'h04, 6'h00);
    cyc(1, 1, 1, 0, 6'h04, 6'h00);
    cyc(1, 0, 1, 0, 6'h04, 6'h00); chk("beq_decode", stb(), 7'b0000000);
    cyc(1, 0, 1, 0, 6'h04, 6'h00); chk("beq_taken", stb(), 7'b0010000);
    chk("beq_pcsel", pcsel, 2'b01);
    cyc(1, 1, 0, 0, 6'h04, 6'h00); chk("beq_refetch", stb(), 7'b1110000);
    cyc(1, 0, 0, 0, 6'h04, 6'h00);
    cyc(1, 0, 0, 0, 6'h04, 6'h00); chk("beq_not_taken", stb(), 7'b0000000);
    cyc(1, 0, 0, 0, 6'h04, 6'h00); chk("beq_nt_refetch", stb(), 7'b1000000);

    // JAL: link write in DECODE.
    cyc(1, 0, 0, 1, 6'h03, 6'h00);
    cyc(1, 1, 0, 0, 6'h03, 6'h00);
    cyc(1, 0, 0, 0, 6'h03, 6'h00); chk("jal_decode", stb(), 7'b0011000);
    chk("jal_sel", {pcsel, wasel, wdsel}, 6'b101000);

    // Illegal opcode.
    cyc(1, 0, 0, 1, 6'h3F, 6'h00);
    cyc(1, 1, 0, 0, 6'h3F, 6'h00);
    cyc(1, 0, 0, 0, 6'h3F, 6'h00); chk("illegal_decode", stb(), 7'b0000010);
    cyc(1, 0, 0, 0, 6'h3F, 6'h00); chk("illegal_refetch", stb(), 7'b1000000);

    // Fetch timeout into HALT, cleared only by reset.
    cyc(1, 0, 0, 1, 6'h00, 6'h20);
    for (int i = 0; i < TO; i++) begin
      cyc(1, 0, 0, 0, 6'h00, 6'h20); chk("to_wait", stb(), 7'b1000000);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 6'h00, 6'h20); chk("halt_quiet", stb(), 7'b0000001);
    end
    cyc(1, 1, 0, 1, 6'h00, 6'h20); chk("halt_reset", stb(), 7'b0000001);
    cyc(1, 0, 0, 0, 6'h00, 6'h20); chk("halt_exit", stb(), 7'b1000000);

    // SW frozen mid-MEM; the wait counter must not advance while frozen.
    to_mem(6'h2B);
    cyc(1, 0, 0, 0, 6'h2B, 6'h00); chk("sw_mem", stb(), 7'b1000100);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0, 6'h2B, 6'h00); chk("sw_frozen", stb(), 7'b0000000);
    end
    cyc(1, 0, 0, 0, 6'h2B, 6'h00); chk("sw_resume", stb(), 7'b1000100);
    cyc(1, 0, 0, 0, 6'h2B, 6'h00); chk("sw_resume", stb(), 7'b1000100);
    cyc(1, 1, 0, 0, 6'h2B, 6'h00); chk("sw_ready", stb(), 7'b1000100);
    cyc(1, 0, 0, 0, 6'h2B, 6'h00); chk("sw_refetch", stb(), 7'b1000000);

    // Reset in the middle of a store.
    to_mem(6'h2B);
    cyc(1, 0, 0, 1, 6'h2B, 6'h00); chk("sw_reset_no_wr", stb(), 7'b0000000);
    cyc(1, 0, 0, 0, 6'h2B, 6'h00); chk("sw_reset_fetch", stb(), 7'b1000000);

    // Random traffic; a new instruction is presented only while fetching.
    ro = 6'h00; rf = 6'h20;
    for (int i = 0; i < 4000; i++) begin
      if (m_ph == 0) begin
        if ($urandom_range(0, 9) != 0) begin
          wcnt = $urandom_range(0, tbl.size() - 1);
          ro = tbl[wcnt].op; rf = tbl[wcnt].fn;
        end else begin
          ro = 6'($urandom); rf = 6'($urandom);
        end
      end
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 5, 1'($urandom),
          (m_ph == 5 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0,
          ro, rf);
    end

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
